// File: rtl/c499_bist_sched_pkg.sv
// Shared types and tap constants for the c499 BIST scheduler slice.
// Optional golden compare is controlled by C499_BIST_GOLDEN_CMP_EN.
package c499_bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // LFSR polynomial x^41 + x^38 + 1 (1-based tap positions)
  localparam int LFSR_TAP_HI = 41;
  localparam int LFSR_TAP_LO = 38;

  // MISR polynomial x^32 + x^22 + x^2 + x + 1 (1-based tap positions)
  localparam int MISR_TAP_A = 32;
  localparam int MISR_TAP_B = 22;
  localparam int MISR_TAP_C = 2;
  localparam int MISR_TAP_D = 1;

  localparam int MISR_W = 32;

  // One MISR compaction step; used where the post-update value is needed early.
  function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0] m,
                                                  input logic [MISR_W-1:0] d);
    logic fb;
    fb = m[MISR_TAP_A-1] ^ m[MISR_TAP_B-1] ^ m[MISR_TAP_C-1] ^ m[MISR_TAP_D-1];
    return {m[MISR_W-2:0], fb} ^ d;
  endfunction

endpackage

// File: rtl/c499_bist_sched_if.sv
// Control/data bundle between a BIST host and the c499 BIST scheduler.
// Golden-compare signals exist only with C499_BIST_GOLDEN_CMP_EN.
interface c499_bist_sched_if #(
  parameter int N_IN  = 41,
  parameter int N_OUT = 32
);
  logic             start;
  logic             abort;
  logic [N_IN-1:0]  dut_in;
  logic [N_OUT-1:0] dut_out;
  logic             busy;
  logic             done;
  logic [15:0]      pat_count;
  logic [N_OUT-1:0] signature;
`ifdef C499_BIST_GOLDEN_CMP_EN
  logic [N_OUT-1:0] golden_sig;
  logic             pass;

  modport slave (
    input  start, abort, dut_out, golden_sig,
    output dut_in, busy, done, pat_count, signature, pass
  );
  modport master (
    output start, abort, dut_out, golden_sig,
    input  dut_in, busy, done, pat_count, signature, pass
  );
`else
  modport slave (
    input  start, abort, dut_out,
    output dut_in, busy, done, pat_count, signature
  );
  modport master (
    output start, abort, dut_out,
    input  dut_in, busy, done, pat_count, signature
  );
`endif
endinterface

// File: rtl/c499_bist_sched_misr.sv
// Multiple-input signature register: clear has priority over compaction.
module c499_bist_misr
  import c499_bist_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_sig
);

  logic [WIDTH-1:0] r_sig;
  logic             w_fb;

  assign w_fb = r_sig[MISR_TAP_A-1] ^ r_sig[MISR_TAP_B-1] ^
                r_sig[MISR_TAP_C-1] ^ r_sig[MISR_TAP_D-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sig <= '0;
    end else if (i_clr) begin
      r_sig <= '0;
    end else if (i_en) begin
      r_sig <= {r_sig[WIDTH-2:0], w_fb} ^ i_data;
    end
  end

  assign o_sig = r_sig;

endmodule

// File: rtl/c499_bist_sched.sv
// BIST scheduler for the registered c499 wrapper: LFSR stimulus, latency pipe, MISR.
// Define C499_BIST_GOLDEN_CMP_EN to build the golden-signature comparator.
module c499_bist_sched
  import c499_bist_pkg::*;
#(
  parameter int              N_IN         = 41,
  parameter int              N_OUT        = 32,
  parameter int              LATENCY      = 2,
  parameter int              NUM_PATTERNS = 256,
  parameter logic [N_IN-1:0] LFSR_SEED    = N_IN'(1)
) (
  input logic             clk,
  input logic             reset_n,
  c499_bist_sched_if.slave bus
);

  localparam logic [N_IN-1:0]    SEED       = (LFSR_SEED == '0) ? N_IN'(1) : LFSR_SEED;
  localparam logic [15:0]        NUM_PAT16  = 16'(NUM_PATTERNS);
  localparam logic [LATENCY-1:0] VALID_LAST = LATENCY'(1) << (LATENCY - 1);

  state_t             r_state;
  logic [N_IN-1:0]    r_lfsr;
  logic [N_IN-1:0]    r_dut_in;
  logic [LATENCY-1:0] r_valid;
  logic [15:0]        r_pat_count;
  logic               r_busy;
  logic               r_done;
  logic               w_start_ok;
  logic               w_misr_en;
  logic [N_OUT-1:0]   w_sig;
`ifdef C499_BIST_GOLDEN_CMP_EN
  logic               r_pass;
`endif

  assign w_start_ok = bus.start && !bus.abort && (r_state == IDLE || r_state == DONE);
  assign w_misr_en  = r_valid[LATENCY-1] && !bus.abort;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_lfsr      <= SEED;
      r_dut_in    <= '0;
      r_valid     <= '0;
      r_pat_count <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef C499_BIST_GOLDEN_CMP_EN
      r_pass      <= 1'b0;
`endif
    end else if (bus.abort) begin
      r_state <= IDLE;
      r_valid <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef C499_BIST_GOLDEN_CMP_EN
      r_pass  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_start_ok) begin
            r_state     <= RUN;
            r_lfsr      <= SEED;
            r_valid     <= '0;
            r_pat_count <= '0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
`ifdef C499_BIST_GOLDEN_CMP_EN
            r_pass      <= 1'b0;
`endif
          end
        end
        RUN: begin
          r_dut_in    <= r_lfsr;
          r_lfsr      <= {r_lfsr[N_IN-2:0], r_lfsr[LFSR_TAP_HI-1] ^ r_lfsr[LFSR_TAP_LO-1]};
          r_valid     <= (r_valid << 1) | LATENCY'(1);
          r_pat_count <= r_pat_count + 16'd1;
          if (r_pat_count + 16'd1 == NUM_PAT16) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          r_valid <= r_valid << 1;
          // The last vector entered at pipe bit 0; it reaches the top after LATENCY-1
          // drain shifts, so this edge is the LATENCY-th drain cycle and the final capture.
          if (r_valid == VALID_LAST) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
`ifdef C499_BIST_GOLDEN_CMP_EN
            r_pass  <= (misr_step(w_sig, bus.dut_out) == bus.golden_sig);
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  c499_bist_misr #(
    .WIDTH (N_OUT)
  ) u_misr (
    .clk     (clk),
    .reset_n (reset_n),
    .i_en    (w_misr_en),
    .i_clr   (w_start_ok),
    .i_data  (bus.dut_out),
    .o_sig   (w_sig)
  );

  assign bus.dut_in    = r_dut_in;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.pat_count = r_pat_count;
  assign bus.signature = w_sig;
`ifdef C499_BIST_GOLDEN_CMP_EN
  assign bus.pass      = r_pass;
`endif

endmodule
